// File: rtl/alu_share_ctrl_if.sv
// Bundle of the request, shared-ALU and response channels around alu_share_ctrl.
// The controller connects through slave; the surrounding environment connects through master.
interface alu_share_ctrl_if #(
    parameter int N = 64
);
    logic         req0_valid;
    logic         req0_ready;
    logic [1:0]   req0_fn;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [1:0]   req1_fn;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [1:0]   alu_fn;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_y;
    logic         alu_of;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_y;
    logic         rsp_zf;
    logic         rsp_sf;
    logic         rsp_of;

    modport slave (
        input  req0_valid, req0_fn, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_fn, req1_a, req1_b,
        output req1_ready,
        output alu_fn, alu_a, alu_b,
        input  alu_y, alu_of,
        output rsp_valid, rsp_id, rsp_y, rsp_zf, rsp_sf, rsp_of,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_fn, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_fn, req1_a, req1_b,
        input  req1_ready,
        input  alu_fn, alu_a, alu_b,
        output alu_y, alu_of,
        input  rsp_valid, rsp_id, rsp_y, rsp_zf, rsp_sf, rsp_of,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin controller that time-shares one external combinational ALU between two
// requesters; operands are registered into the ALU and the result plus flags are returned.
module alu_share_ctrl #(
    parameter int N = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_share_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last_grant;
    logic         r_owner;
    logic [1:0]   r_alu_fn;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [N-1:0] r_rsp_y;
    logic         r_rsp_id;
    logic         r_rsp_zf;
    logic         r_rsp_sf;
    logic         r_rsp_of;
    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_hs0;
    logic         w_hs1;

    // Overflow only has meaning for add/sub; logic ops (fn[1]=1) report 0.
    function automatic logic f_keep_of(input logic [1:0] fn, input logic of);
        return of & ~fn[1];
    endfunction

    always_comb begin
        w_gnt0      = bus.req0_valid && (!bus.req1_valid || r_last_grant);
        w_gnt1      = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
        w_hs0       = 1'b0;
        w_hs1       = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_hs0 = rst_n && w_gnt0;
                w_hs1 = rst_n && w_gnt1;
                if (w_hs0 || w_hs1) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_DONE;
            S_DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_alu_fn     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_y      <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_zf     <= 1'b0;
            r_rsp_sf     <= 1'b0;
            r_rsp_of     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs0) begin
                r_alu_fn <= bus.req0_fn;
                r_alu_a  <= bus.req0_a;
                r_alu_b  <= bus.req0_b;
                r_owner  <= 1'b0;
            end else if (w_hs1) begin
                r_alu_fn <= bus.req1_fn;
                r_alu_a  <= bus.req1_a;
                r_alu_b  <= bus.req1_b;
                r_owner  <= 1'b1;
            end
            // EXEC -> DONE: capture the shared ALU result for the owner
            if (r_state == S_EXEC) begin
                r_rsp_y      <= bus.alu_y;
                r_rsp_zf     <= (bus.alu_y == '0);
                r_rsp_sf     <= bus.alu_y[N-1];
                r_rsp_of     <= f_keep_of(r_alu_fn, bus.alu_of);
                r_rsp_id     <= r_owner;
                r_last_grant <= r_owner;
            end
        end
    end

    assign bus.req0_ready = w_hs0;
    assign bus.req1_ready = w_hs1;
    assign bus.alu_fn     = r_alu_fn;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.rsp_valid  = (r_state == S_DONE);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_y      = r_rsp_y;
    assign bus.rsp_zf     = r_rsp_zf;
    assign bus.rsp_sf     = r_rsp_sf;
    assign bus.rsp_of     = r_rsp_of;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed-vector bench for alu_share_ctrl with a behavioural shared ALU and a response scoreboard.
module tb_alu_share_ctrl;
    typedef struct packed {
        logic        id;
        logic [63:0] y;
        logic        zf;
        logic        sf;
        logic        of;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_of = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    rsp_t exp_q[$];
    rsp_t mon_act;
    rsp_t mon_exp;
    logic [63:0] m_y;
    logic        m_of;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    alu_share_ctrl_if #(.N(64)) bus ();

    alu_share_ctrl #(.N(64)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Behavioural shared ALU; force_of pins the overflow flag high.
    always_comb begin
        m_y  = '0;
        m_of = 1'b0;
        case (bus.alu_fn)
            2'd0: begin
                m_y  = bus.alu_a + bus.alu_b;
                m_of = (bus.alu_a[63] == bus.alu_b[63]) && (m_y[63] != bus.alu_a[63]);
            end
            2'd1: begin
                m_y  = bus.alu_a + ~bus.alu_b + 64'd1;
                m_of = (bus.alu_a[63] != bus.alu_b[63]) && (m_y[63] != bus.alu_a[63]);
            end
            2'd2: m_y = bus.alu_a & bus.alu_b;
            default: m_y = bus.alu_a ^ bus.alu_b;
        endcase
        if (force_of) m_of = 1'b1;
    end
    assign bus.alu_y  = m_y;
    assign bus.alu_of = m_of;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            mon_act = {bus.rsp_id, bus.rsp_y, bus.rsp_zf, bus.rsp_sf, bus.rsp_of};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %0h expected no response", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rsp{id,y,zf,sf,of}", mon_act, mon_exp);
            end
        end
    end

    task automatic push(input logic id, input logic [63:0] y, input logic zf, input logic sf,
                        input logic of);
        rsp_t e;
        e = {id, y, zf, sf, of};
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int id, input logic v, input logic [1:0] fn,
                           input logic [63:0] a, input logic [63:0] b);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_fn = fn; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_fn = fn; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Returns at posedge+1 right after the handshake edge (state is then EXEC).
    task automatic req_op(input int id, input logic [1:0] fn, input logic [63:0] a,
                          input logic [63:0] b, output int waited);
        logic rdy;
        @(posedge clk); #1;
        set_req(id, 1'b1, fn, a, b);
        waited = 0;
        forever begin
            @(negedge clk);
            rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL req%0d_timeout: got no ready expected ready within 50 cycles", id);
                break;
            end
        end
        @(posedge clk); #1;
        set_req(id, 1'b0, fn, a, b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish by 300us");
        $fatal(1);
    end

    initial begin
        int w;
        int g;
        int n;
        logic gid [4];
        int   gcyc[4];

        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 2'd0, 64'd1, 64'd1);
        set_req(1, 1'b0, 2'd0, 64'd0, 64'd0);

        // Reset state, with req0 valid during reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_rsp_y", bus.rsp_y, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 1'b0, 2'd0, 64'd0, 64'd0);

        // Single add with latency checks
        push(1'b0, 64'd12, 1'b0, 1'b0, 1'b0);
        req_op(0, 2'd0, 64'd5, 64'd7, w);
        chk("t1_first_idle_ready", w, 0);
        @(negedge clk);
        chk("t1_exec_rsp_valid", bus.rsp_valid, 0);
        chk("t1_exec_alu_a", bus.alu_a, 5);
        chk("t1_exec_alu_b", bus.alu_b, 7);
        @(negedge clk);
        chk("t1_done_rsp_valid", bus.rsp_valid, 1);
        drain();

        // Sub to zero, then signed overflow
        push(1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
        req_op(1, 2'd1, 64'h1234, 64'h1234, w);
        drain();
        push(1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        req_op(0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, w);
        drain();

        // Overflow forced by the ALU: kept for add, masked for logic ops
        force_of = 1'b1;
        push(1'b0, 64'd2, 1'b0, 1'b0, 1'b1);
        req_op(0, 2'd0, 64'd1, 64'd1, w);
        drain();
        push(1'b1, 64'hF0F0, 1'b0, 1'b0, 1'b0);
        req_op(1, 2'd3, 64'hFF00, 64'h0FF0, w);
        drain();
        push(1'b1, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0);
        req_op(1, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, w);
        drain();
        force_of = 1'b0;

        // Both requesters continuously valid
        @(posedge clk); #1;
        set_req(0, 1'b1, 2'd0, 64'd10, 64'd20);
        set_req(1, 1'b1, 2'd1, 64'd100, 64'd1);
        g = 0;
        n = 0;
        while (g < 4 && n < 60) begin
            @(negedge clk);
            n++;
            chk("t4_one_hot_ready", bus.req0_ready && bus.req1_ready, 0);
            if (bus.req0_ready || bus.req1_ready) begin
                gid[g]  = bus.req1_ready;
                gcyc[g] = cyc;
                if (bus.req1_ready) push(1'b1, 64'd99, 1'b0, 1'b0, 1'b0);
                else                push(1'b0, 64'd30, 1'b0, 1'b0, 1'b0);
                g++;
            end
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'd0, 64'd0, 64'd0);
        set_req(1, 1'b0, 2'd0, 64'd0, 64'd0);
        chk("t4_grant_count", g, 4);
        if (g == 4) begin
            chk("t4_grant0", gid[0], 0);
            chk("t4_grant1", gid[1], 1);
            chk("t4_grant2", gid[2], 0);
            chk("t4_grant3", gid[3], 1);
            for (int i = 1; i < 4; i++) chk("t4_grant_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        drain();

        // Backpressure with req1 waiting
        bus.rsp_ready = 1'b0;
        push(1'b0, 64'd7, 1'b0, 1'b0, 1'b0);
        req_op(0, 2'd0, 64'd3, 64'd4, w);
        set_req(1, 1'b1, 2'd1, 64'd50, 64'd8);
        @(negedge clk);
        chk("t5_exec_req1_ready", bus.req1_ready, 0);
        repeat (5) begin
            @(negedge clk);
            chk("t5_bp_rsp_valid", bus.rsp_valid, 1);
            chk("t5_bp_rsp_y", bus.rsp_y, 7);
            chk("t5_bp_rsp_id", bus.rsp_id, 0);
            chk("t5_bp_req1_ready", bus.req1_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        push(1'b1, 64'd42, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_release_req1_ready", bus.req1_ready, 0);
        @(negedge clk);
        chk("t5_next_req1_ready", bus.req1_ready, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 2'd0, 64'd0, 64'd0);
        drain();

        // Reset mid-EXEC after a req0 op, so only reset can bring the pointer back to 1
        push(1'b0, 64'h33, 1'b0, 1'b0, 1'b0);
        req_op(0, 2'd0, 64'h11, 64'h22, w);
        drain();
        req_op(1, 2'd3, 64'd5, 64'd3, w);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rsp_y", bus.rsp_y, 0);
        chk("t6_rsp_flags", {bus.rsp_id, bus.rsp_zf, bus.rsp_sf, bus.rsp_of}, 0);
        chk("t6_alu_fn", bus.alu_fn, 0);
        chk("t6_alu_a", bus.alu_a, 0);
        chk("t6_alu_b", bus.alu_b, 0);
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_rsp_valid", bus.rsp_valid, 0);
        end
        @(posedge clk); #1;
        push(1'b0, 64'd3, 1'b0, 1'b0, 1'b0);
        set_req(0, 1'b1, 2'd0, 64'd1, 64'd2);
        set_req(1, 1'b1, 2'd0, 64'd4, 64'd5);
        @(negedge clk);
        chk("t6_tie_req0_ready", bus.req0_ready, 1);
        chk("t6_tie_req1_ready", bus.req1_ready, 0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'd0, 64'd0, 64'd0);
        push(1'b1, 64'd9, 1'b0, 1'b0, 1'b0);
        req_op(1, 2'd0, 64'd4, 64'd5, w);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Controller that time-shares one combinational 64-bit ALU (add / sub / and / xor, with the 64-bit NOT used for subtraction) between two requesters, for example the execute stage and an address-generation unit. It arbitrates round-robin, registers operands into the shared ALU, captures its result and condition codes, and returns them on a single response channel with a valid/ready handshake. The block contains no arithmetic of its own except zero and sign detection on the captured result.

## Interface
Parameters:
- N, 64, datapath width in bits.

Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on the rising edge.
- rst_n, in, 1, synchronous active-low reset, sampled on the rising clk edge.
- req0_valid, in, 1, requester 0 has an operation pending.
- req0_ready, out, 1, requester 0's operation is accepted this cycle.
- req0_fn, in, 2, operation code: 0 add, 1 sub, 2 and, 3 xor.
- req0_a, in, N, operand a.
- req0_b, in, N, operand b.
- req1_valid / req1_ready / req1_fn / req1_a / req1_b: same as the requester 0 ports, for requester 1.
- alu_fn, out, 2, registered function code driven to the shared ALU.
- alu_a, out, N, registered operand a driven to the shared ALU.
- alu_b, out, N, registered operand b driven to the shared ALU.
- alu_y, in, N, combinational ALU result.
- alu_of, in, 1, combinational ALU signed-overflow flag.
- rsp_valid, out, 1, a result is available.
- rsp_ready, in, 1, the consumer takes the result.
- rsp_id, out, 1, which requester owns the result.
- rsp_y, out, N, the result.
- rsp_zf, out, 1, zero flag.
- rsp_sf, out, 1, sign flag.
- rsp_of, out, 1, overflow flag.

## Operation
State machine with three states.
- IDLE
  - Arbitrates the requesters.
  - Grant goes to the only valid requester; if both are valid, it goes to the requester not served last (last_grant pointer).
  - reqX_ready is a combinational 1 only when state is IDLE and X is granted. At most one ready is high in any cycle.
  - On the handshake: latch fn/a/b into the alu_* registers, latch the owner, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC, one cycle. The alu_* outputs are stable. At the end of the cycle, capture:
  - rsp_y = alu_y.
  - rsp_zf = (alu_y == 0).
  - rsp_sf = alu_y[N-1].
  - rsp_of = alu_of for fn 0/1, forced to 0 for fn 2/3.
  - rsp_id = owner; last_grant = owner.
  - Then go to DONE.
- DONE
  - rsp_valid = 1, with all rsp_* outputs held stable.
  - When rsp_ready = 1, go to IDLE.
  - Otherwise stay in DONE; no new grants are issued.
- Requester rules
  - A requester holds valid, fn, a and b stable until it sees ready.
  - The block samples operands only on the handshake cycle.
  - Dropping valid before ready is legal; the operation is then not performed.
- Response rules
  - rsp_ready is ignored outside DONE.
  - Exactly one response is produced per accepted request, in acceptance order.
- Reset (rst_n = 0 at a rising edge)
  - State returns to IDLE.
  - All alu_* and rsp_* outputs become 0, and rsp_valid becomes 0.
  - last_grant is set to 1, so requester 0 wins the first tie.
  - req*_ready is 0 while rst_n is low.
  - Reset in EXEC or DONE abandons the operation; no response is produced.

## Timing
- Handshake at edge T → EXEC during cycle T+1 → rsp_valid = 1 from edge T+2.
- Minimum of 3 cycles per operation (IDLE, EXEC, DONE with rsp_ready already 1). Maximum throughput is one operation per 3 cycles.
- rsp_* outputs change only on the EXEC→DONE edge or on reset.
- alu_* outputs change only on the grant edge or on reset. They hold their last value while idle.
- No combinational path from req*_valid to alu_* or rsp_*. The only combinational outputs are req*_ready, which depend on state, last_grant and req*_valid.

## Test plan
- Reset, then a single add.
  - Stimulus: req0 fn=0, a=5, b=7.
  - Required: req0_ready high in the first IDLE cycle; rsp_valid two edges later with rsp_y=12, zf=0, sf=0, of=0, rsp_id=0.
- Sub to zero, then signed overflow.
  - Stimulus: req1 sub with equal operands. ALU model returns 0 → rsp_zf=1, rsp_id=1.
  - Stimulus: req0 add a=0x7FFF_FFFF_FFFF_FFFF, b=1.
  - Required: rsp_y=0x8000_0000_0000_0000, sf=1, of=1.
- Logic op masks overflow.
  - Stimulus: xor with the ALU model forcing alu_of=1.
  - Required: rsp_of=0.
- Both requesters held valid continuously for 4 operations, rsp_ready tied to 1.
  - Required: grants in the order 0, 1, 0, 1; one grant per 3 cycles; never both ready high.
- Backpressure.
  - Stimulus: rsp_ready held low for 5 cycles in DONE while req1 is valid.
  - Required: rsp_* stable, req1_ready stays 0; grant to req1 follows the cycle after rsp_ready rises.
- Reset mid-EXEC.
  - Required: no rsp_valid afterwards, all outputs 0; next tie is granted to req0.
